mmio_key_input: RTL and testbench
=================================

// Module: mmio_key_input
// PURPOSE
//  Memory-mapped input peripheral on the shared 32-bit processor bus: the input-side
//  counterpart to the memory-mapped output register. Synchronises and debounces raw
//  push-button/switch lines and exposes their state through a DATA register.
//  Latches press events in an edge-capture register (CTRL) and raises an interrupt
//  request to the processor when enabled.
// PARAMETERS
//  ADDRESS_DATA     32'h0000_F010  bus address of read-only debounced-state register
//  ADDRESS_CTRL     32'h0000_F014  bus address of edge-capture / interrupt-enable register
//  INPUT_WIDTH      4              number of input lines (1..31)
//  DEBOUNCE_CYCLES  50000          consecutive stable edges required to accept a change (>=1)
//  ACTIVE_LOW       1              1: raw line low = pressed; 0: raw line high = pressed
// PORTS
//  clk      in     1            system clock; all state updates on negedge clk (bus write timing)
//  rst_n    in     1            asynchronous active-low reset
//  writeEn  in     1            bus write strobe
//  addr     in     32           bus address
//  bus      inout  32           shared data bus
//  keys     in     INPUT_WIDTH  raw asynchronous input lines
//  irq      out    1            interrupt request = IE & |pending
// BEHAVIOUR
//  Reset (rst_n=0, async): sync FFs, debounced state, counters, pending, IE all 0; irq=0;
//   bus released (Z). "0" in sync/debounced means released (after ACTIVE_LOW inversion).
//  Input path per bit: p = ACTIVE_LOW ? ~keys : keys -> 2-FF synchroniser -> s.
//  Debounce per bit: counter cnt (width $clog2(DEBOUNCE_CYCLES+1)).
//   - s == deb: cnt <= 0.
//   - s != deb and cnt == DEBOUNCE_CYCLES-1: deb <= s, cnt <= 0.
//   - s != deb otherwise: cnt <= cnt+1.
//   - Any glitch back to deb before acceptance restarts count from 0.
//   - Latency: raw change held stable -> deb changes on edge 2+DEBOUNCE_CYCLES.
//  Edge capture: pending[i] set on the same edge deb[i] goes 0->1 (press only).
//   Release (1->0) does not set pending. Pending is sticky until cleared by software.
//  Bus read (addr match & ~writeEn): combinational drive, zero-extended:
//   DATA: {0, deb[INPUT_WIDTH-1:0]}
//   CTRL: {IE, 0, pending[INPUT_WIDTH-1:0]}, IE at bit 31.
//   No address match, or writeEn=1: bus = 32'hZ.
//  Bus write (addr match & writeEn, sampled on negedge clk):
//   CTRL: pending[i] cleared where bus[i]=1 (write-1-to-clear); IE <= bus[31].
//   DATA: write ignored, no state change.
//  Simultaneous set and clear of the same pending bit on one edge: set wins (pending=1).
//  irq: combinational from registers; asserts when IE=1 and any pending bit is set.
//   Deasserts once the last pending bit is cleared or IE is written 0.
//  Reset mid-debounce: count discarded, deb stays 0, no pending set.
//  Reads have no side effects; reading CTRL does not clear pending.
// TESTING  (INPUT_WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, DATA=0xF010, CTRL=0xF014)
//  1 Reset, keys=4'hF, read DATA/CTRL, and also idle with a foreign addr
//    -> DATA=0, CTRL=0, irq=0; bus=Z when addr is not DATA or CTRL.
//  2 keys[0]=0 held 10 cycles -> DATA reads 0x1 exactly from edge 6; CTRL reads 0x1.
//    Release keys[0] and hold -> DATA=0 after 6 edges; CTRL still 0x1.
//  3 keys[1] bounces 0 for 2 cycles / 1 for 1 cycle, repeated 5 times
//    -> DATA stays 0; CTRL stays 0.
//  4 Press bit2, write CTRL=0x8000_0000 -> irq=1.
//    Write CTRL=0x8000_0004 -> pending=0, irq=0, IE remains 1.
//  5 Write-1-to-clear of bit3 on the same edge bit3 debounces pressed
//    -> CTRL bit3 reads 1 afterwards.
//  6 Assert rst_n during the 3rd stable cycle of a press, then release rst_n with key still held
//    -> DATA=0 throughout reset; DATA=1 on 6th edge after reset release.

Source files
------------

// File: rtl/mmio_key_input.sv
// mmio_key_input: bus-mapped debounced key inputs with press capture and interrupt
module mmio_key_input #(
   parameter logic [31:0] ADDRESS_DATA    = 32'h0000_F010,
   parameter logic [31:0] ADDRESS_CTRL    = 32'h0000_F014,
   parameter int          INPUT_WIDTH     = 4,
   parameter int          DEBOUNCE_CYCLES = 50000,
   parameter bit          ACTIVE_LOW      = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   writeEn,
   input  logic [31:0]            addr,
   inout  wire  [31:0]            bus,
   input  logic [INPUT_WIDTH-1:0] keys,
   output logic                   irq
);
   localparam int cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
   logic [INPUT_WIDTH-1:0] p, sync1, s, deb, pending, accept, clr;
   logic [cnt_w-1:0] cnt [INPUT_WIDTH];
   logic ie, sel_data, sel_ctrl, wr_ctrl;
   logic [31:0] rdata;
   assign p = ACTIVE_LOW ? ~keys : keys;
   assign sel_data = addr == ADDRESS_DATA;
   assign sel_ctrl = addr == ADDRESS_CTRL;
   assign wr_ctrl = writeEn & sel_ctrl;
   assign clr = wr_ctrl ? bus[INPUT_WIDTH-1:0] : '0;
   assign rdata = sel_ctrl ? {ie, 31'(pending)} : 32'(deb);
   assign bus = (~writeEn & (sel_data | sel_ctrl)) ? rdata : 'z;
   assign irq = ie & |pending;
   always_comb begin
      accept = '0;
      for (int i = 0; i < INPUT_WIDTH; i++)
         accept[i] = (s[i] != deb[i]) && (cnt[i] == cnt_w'(DEBOUNCE_CYCLES - 1));
   end
   // a newly accepted press sets pending after the clear mask, so set wins
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         s <= '0;
         deb <= '0;
         pending <= '0;
         ie <= 1'b0;
         for (int i = 0; i < INPUT_WIDTH; i++) cnt[i] <= '0;
      end else begin
         sync1 <= p;
         s <= sync1;
         for (int i = 0; i < INPUT_WIDTH; i++)
            cnt[i] <= (s[i] == deb[i] || accept[i]) ? '0 : cnt[i] + cnt_w'(1);
         deb <= deb ^ accept;
         pending <= (pending & ~clr) | (accept & s);
         if (wr_ctrl) ie <= bus[31];
      end
   end
endmodule

// File: tb/tb_mmio_key_input.sv
// tb_mmio_key_input: scoreboard bench for the key input peripheral
module tb_mmio_key_input;
   localparam logic [31:0] da = 32'h0000_F010;
   localparam logic [31:0] ca = 32'h0000_F014;
   logic clk = 1'b0, rst_n = 1'b0, writeEn = 1'b0, oe = 1'b0, chk = 1'b0;
   logic [31:0] addr = '0, drv = '0;
   logic [3:0] keys = 4'hF;
   logic irq;
   tri1 [31:0] bus;
   int compared = 0, mismatched = 0;
   logic [32:0] exp_q [$];
   string name_q [$];
   logic [32:0] e;
   string n;
   assign bus = oe ? drv : 'z;
   mmio_key_input #(.ADDRESS_DATA(da), .ADDRESS_CTRL(ca), .INPUT_WIDTH(4),
      .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) dut (
      .clk(clk), .rst_n(rst_n), .writeEn(writeEn), .addr(addr),
      .bus(bus), .keys(keys), .irq(irq));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (chk) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_read: got irq=%0b bus=%h, no expected entry", irq, bus);
         end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if ({irq, bus} !== e) begin
               mismatched++;
               $display("FAIL %s: got irq=%0b bus=%h, required irq=%0b bus=%h",
                  n, irq, bus, e[32], e[31:0]);
            end
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic rd(input logic [31:0] a, input logic [31:0] v, input logic i, input string nm);
      addr = a;
      writeEn = 1'b0;
      oe = 1'b0;
      chk = 1'b1;
      exp_q.push_back({i, v});
      name_q.push_back(nm);
      step();
      chk = 1'b0;
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      writeEn = 1'b1;
      oe = 1'b1;
      drv = d;
      chk = 1'b0;
      step();
      writeEn = 1'b0;
      oe = 1'b0;
      addr = '0;
   endtask
   initial begin
      rd(da, 32'h0, 1'b0, "rst_data");
      rd(ca, 32'h0, 1'b0, "rst_ctrl");
      rd(32'h0000_F018, 32'hFFFF_FFFF, 1'b0, "rst_foreign_z");
      rst_n = 1'b1;
      step();
      rd(da, 32'h0, 1'b0, "idle_data");
      rd(ca, 32'h0, 1'b0, "idle_ctrl");
      keys = 4'hE;
      for (int k = 1; k <= 10; k++) rd(da, (k >= 6) ? 32'h1 : 32'h0, 1'b0, "press_data");
      rd(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "foreign_z");
      rd(ca, 32'h1, 1'b0, "press_ctrl");
      keys = 4'hF;
      for (int k = 1; k <= 6; k++) rd(da, (k >= 6) ? 32'h0 : 32'h1, 1'b0, "release_data");
      rd(ca, 32'h1, 1'b0, "release_ctrl");
      wr(ca, 32'h1);
      rd(ca, 32'h0, 1'b0, "w1c_ctrl");
      for (int r = 0; r < 5; r++) begin
         keys = 4'hD;
         rd(da, 32'h0, 1'b0, "bounce_data");
         rd(da, 32'h0, 1'b0, "bounce_data");
         keys = 4'hF;
         rd(da, 32'h0, 1'b0, "bounce_data");
      end
      repeat (4) step();
      rd(ca, 32'h0, 1'b0, "bounce_ctrl");
      keys = 4'hB;
      repeat (8) step();
      rd(ca, 32'h4, 1'b0, "bit2_pending");
      wr(ca, 32'h8000_0000);
      rd(ca, 32'h8000_0004, 1'b1, "ie_irq");
      wr(ca, 32'h8000_0004);
      rd(ca, 32'h8000_0000, 1'b0, "clear_irq");
      keys = 4'hF;
      repeat (8) step();
      rd(ca, 32'h8000_0000, 1'b0, "release_no_pend");
      keys = 4'h7;
      repeat (5) step();
      wr(ca, 32'h8000_0008);
      rd(ca, 32'h8000_0008, 1'b1, "set_wins");
      wr(ca, 32'h0);
      rd(ca, 32'h8, 1'b0, "ie_off");
      wr(da, 32'h0);
      rd(da, 32'h8, 1'b0, "data_ro");
      keys = 4'hF;
      repeat (8) step();
      keys = 4'hE;
      repeat (3) step();
      rst_n = 1'b0;
      rd(da, 32'h0, 1'b0, "rst_mid_data");
      rd(da, 32'h0, 1'b0, "rst_mid_data");
      rd(ca, 32'h0, 1'b0, "rst_mid_ctrl");
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) rd(da, (k >= 6) ? 32'h1 : 32'h0, 1'b0, "post_rst_data");
      rd(ca, 32'h1, 1'b0, "post_rst_ctrl");
      step();
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: got %0d left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
